// File: rtl/data_cache_dm_if.sv
// CPU-side request/response and backing-memory handshake signals of the data cache.
interface data_cache_dm_if;
  // Load/store unit side
  logic        req;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  mask;
  logic        we;
  logic [31:0] rdata;
  logic        valid;
  logic        stall;
  // Backing memory side
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_mask;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  req, addr, wdata, mask, we, mem_ack, mem_rdata,
    output rdata, valid, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_mask
  );

  modport master (
    output req, addr, wdata, mask, we, mem_ack, mem_rdata,
    input  rdata, valid, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_mask
  );
endinterface

// File: rtl/data_cache_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache of one-word lines,
// with memory-mapped GPIO words and a request/valid/stall CPU protocol.
module data_cache_dm #(
  parameter int          LINES     = 256,
  parameter int          GPIO_CH   = 2,
  parameter logic [31:0] MMIO_BASE = 32'h0000_0000
) (
  input  logic                   I_clk,
  input  logic                   I_rst,
  data_cache_dm_if.slave         bus,
  input  logic [32*GPIO_CH-1:0]  I_gpio,
  output logic [32*GPIO_CH-1:0]  O_gpio
);

  localparam int          IDX_W      = $clog2(LINES);
  localparam int          TAG_W      = 30 - IDX_W;
  localparam logic [29:0] MMIO_WBASE = MMIO_BASE[31:2];

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_FILL, S_WRITE} state_t;

  state_t           state_q;
  logic [LINES-1:0] vld_q;
  logic [31:0]      data_mem [LINES];
  logic [TAG_W-1:0] tag_mem  [LINES];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [29:0]      mmio_off;
  logic [2:0]       gpio_k;
  logic             is_mmio;
  logic             hit;
  logic             unused_addr_lsb;

  // Replace the bytes of old_w selected by m with the matching bytes of new_w.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  m);
    merge_bytes = old_w;
    for (int b = 0; b < 4; b++)
      if (m[b]) merge_bytes[8*b +: 8] = new_w[8*b +: 8];
  endfunction

  // Request classification, all done in the acceptance cycle.
  assign idx             = bus.addr[IDX_W+1:2];
  assign tag             = bus.addr[31:IDX_W+2];
  assign mmio_off        = bus.addr[31:2] - MMIO_WBASE;
  assign is_mmio         = (mmio_off < 30'(GPIO_CH));
  assign gpio_k          = mmio_off[2:0];
  assign hit             = vld_q[idx] && (tag_mem[idx] == tag);
  assign bus.stall       = (state_q != S_IDLE);
  assign unused_addr_lsb = ^bus.addr[1:0];

  // Control FSM with registered CPU, GPIO and backing-bus outputs.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q       <= S_INIT;
      vld_q         <= '0;
      bus.rdata     <= '0;
      bus.valid     <= 1'b0;
      O_gpio        <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_mask  <= '0;
    end else begin
      bus.valid <= 1'b0;
      case (state_q)
        S_INIT: state_q <= S_IDLE;
        S_IDLE: begin
          if (bus.req) begin
            if (is_mmio) begin
              if (bus.we)
                O_gpio[32*int'(gpio_k) +: 32] <=
                  merge_bytes(O_gpio[32*int'(gpio_k) +: 32], bus.wdata, bus.mask);
              else
                bus.rdata <= I_gpio[32*int'(gpio_k) +: 32];
              bus.valid <= 1'b1;
            end else if (!bus.we) begin
              if (hit) begin
                bus.rdata <= data_mem[idx];
                bus.valid <= 1'b1;
              end else begin
                bus.mem_req  <= 1'b1;
                bus.mem_we   <= 1'b0;
                bus.mem_addr <= bus.addr[31:2];
                bus.mem_mask <= 4'hF;
                state_q      <= S_FILL;
              end
            end else if (bus.mask == 4'h0) begin
              bus.valid <= 1'b1;
            end else begin
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= bus.addr[31:2];
              bus.mem_wdata <= bus.wdata;
              bus.mem_mask  <= bus.mask;
              state_q       <= S_WRITE;
            end
          end
        end
        S_FILL: begin
          if (bus.mem_ack) begin
            bus.mem_req                      <= 1'b0;
            bus.rdata                        <= bus.mem_rdata;
            bus.valid                        <= 1'b1;
            vld_q[bus.mem_addr[IDX_W-1:0]]   <= 1'b1;
            state_q                          <= S_IDLE;
          end
        end
        S_WRITE: begin
          if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            bus.valid   <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  // Line storage: store hits merge at once, fills replace data and tag.
  always_ff @(posedge I_clk) begin
    if (state_q == S_IDLE && bus.req && !is_mmio && bus.we && hit) begin
      data_mem[idx] <= merge_bytes(data_mem[idx], bus.wdata, bus.mask);
    end else if (state_q == S_FILL && bus.mem_ack) begin
      data_mem[bus.mem_addr[IDX_W-1:0]] <= bus.mem_rdata;
      tag_mem[bus.mem_addr[IDX_W-1:0]]  <= bus.mem_addr[29:IDX_W];
    end
  end

endmodule

// File: tb/tb_data_cache_dm.sv
// Directed bench for data_cache_dm: reset, miss/hit, masked store, aliasing,
// GPIO access and reset during a pending fill.
module tb_data_cache_dm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] gpio_in;
  logic [63:0] gpio_out;
  int          n_tests = 0;
  int          n_fail  = 0;

  data_cache_dm_if bus();

  data_cache_dm #(.LINES(256), .GPIO_CH(2), .MMIO_BASE(32'h0)) dut (
    .I_clk (clk),
    .I_rst (rst),
    .bus   (bus),
    .I_gpio(gpio_in),
    .O_gpio(gpio_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for exactly one cycle (accepted at the next edge while idle).
  task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] m);
    bus.req = 1'b1; bus.addr = a; bus.we = w; bus.wdata = d; bus.mask = m;
    tick();
    bus.req = 1'b0;
  endtask

  // Act as backing memory: raise ack in the delay-th stalled cycle; n returns stalled cycles seen.
  task automatic serve(input int delay, input logic [31:0] rd, output int n);
    n = 0;
    while (bus.stall && n < 50) begin
      n++;
      if (n == delay) begin bus.mem_ack = 1'b1; bus.mem_rdata = rd; end
      tick();
    end
    bus.mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_tests++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL rst_stall got=%b exp=1", bus.stall); end
    n_tests++; if (gpio_out !== 64'h0) begin n_fail++; $display("FAIL rst_gpio got=%h exp=0", gpio_out); end
    n_tests++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req got=%b exp=0", bus.mem_req); end
    n_tests++; if (bus.valid !== 1'b0 || bus.rdata !== 32'h0) begin n_fail++; $display("FAIL rst_out got valid=%b data=%h exp 0/0", bus.valid, bus.rdata); end
    rst = 1'b0;
    #1;
    n_tests++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL init_stall got=%b exp=1", bus.stall); end
    tick();
    n_tests++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL idle_stall got=%b exp=0", bus.stall); end
  endtask

  task automatic test_miss_hit();
    int n;
    issue(32'h100, 1'b0, 32'h0, 4'hF);
    n_tests++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL miss_req got req=%b we=%b exp 1/0", bus.mem_req, bus.mem_we); end
    n_tests++; if (bus.mem_addr !== 30'h40 || bus.mem_mask !== 4'hF) begin n_fail++; $display("FAIL miss_addr got addr=%h mask=%h exp 40/f", bus.mem_addr, bus.mem_mask); end
    serve(4, 32'hDEADBEEF, n);
    n_tests++; if (n !== 4) begin n_fail++; $display("FAIL miss_stall_cycles got=%0d exp=4", n); end
    n_tests++; if (bus.valid !== 1'b1 || bus.rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL miss_data got valid=%b data=%h exp 1/deadbeef", bus.valid, bus.rdata); end
    n_tests++; if (bus.mem_req !== 1'b0 || bus.stall !== 1'b0) begin n_fail++; $display("FAIL miss_done got req=%b stall=%b exp 0/0", bus.mem_req, bus.stall); end
    tick();
    n_tests++; if (bus.valid !== 1'b0 || bus.rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL valid_pulse got valid=%b data=%h exp 0/deadbeef", bus.valid, bus.rdata); end
    issue(32'h100, 1'b0, 32'h0, 4'hF);
    n_tests++; if (bus.valid !== 1'b1 || bus.rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL hit_data got valid=%b data=%h exp 1/deadbeef", bus.valid, bus.rdata); end
    n_tests++; if (bus.mem_req !== 1'b0 || bus.stall !== 1'b0) begin n_fail++; $display("FAIL hit_nobus got req=%b stall=%b exp 0/0", bus.mem_req, bus.stall); end
    tick();
  endtask

  task automatic test_store();
    int n;
    issue(32'h100, 1'b1, 32'h11223344, 4'b0101);
    n_tests++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_mask !== 4'b0101) begin n_fail++; $display("FAIL st_req got req=%b we=%b mask=%b exp 1/1/0101", bus.mem_req, bus.mem_we, bus.mem_mask); end
    n_tests++; if (bus.mem_wdata !== 32'h11223344 || bus.mem_addr !== 30'h40) begin n_fail++; $display("FAIL st_bus got data=%h addr=%h exp 11223344/40", bus.mem_wdata, bus.mem_addr); end
    serve(2, 32'h0, n);
    n_tests++; if (n !== 2 || bus.valid !== 1'b1 || bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL st_done got n=%0d valid=%b req=%b exp 2/1/0", n, bus.valid, bus.mem_req); end
    tick();
    issue(32'h100, 1'b0, 32'h0, 4'hF);
    n_tests++; if (bus.valid !== 1'b1 || bus.rdata !== 32'hDE22BE44 || bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL st_reload got valid=%b data=%h req=%b exp 1/de22be44/0", bus.valid, bus.rdata, bus.mem_req); end
    tick();
  endtask

  task automatic test_alias();
    int n;
    issue(32'h500, 1'b0, 32'h0, 4'hF);
    n_tests++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 30'h140) begin n_fail++; $display("FAIL alias_miss1 got req=%b addr=%h exp 1/140", bus.mem_req, bus.mem_addr); end
    serve(1, 32'hCAFEF00D, n);
    n_tests++; if (bus.valid !== 1'b1 || bus.rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL alias_data1 got valid=%b data=%h exp 1/cafef00d", bus.valid, bus.rdata); end
    tick();
    issue(32'h100, 1'b0, 32'h0, 4'hF);
    n_tests++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 30'h40) begin n_fail++; $display("FAIL alias_evict got req=%b addr=%h exp 1/40", bus.mem_req, bus.mem_addr); end
    serve(2, 32'hDE22BE44, n);
    n_tests++; if (bus.valid !== 1'b1 || bus.rdata !== 32'hDE22BE44) begin n_fail++; $display("FAIL alias_data2 got valid=%b data=%h exp 1/de22be44", bus.valid, bus.rdata); end
    tick();
    issue(32'h500, 1'b0, 32'h0, 4'hF);
    n_tests++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL alias_evicted got req=%b exp 1", bus.mem_req); end
    serve(1, 32'hCAFEF00D, n);
    tick();
  endtask

  task automatic test_mmio();
    issue(32'h4, 1'b1, 32'hA5A5A5A5, 4'b1000);
    n_tests++; if (gpio_out !== 64'hA5000000_00000000) begin n_fail++; $display("FAIL gpio_store got=%h exp=a500000000000000", gpio_out); end
    n_tests++; if (bus.valid !== 1'b1 || bus.mem_req !== 1'b0 || bus.stall !== 1'b0) begin n_fail++; $display("FAIL gpio_st_nobus got valid=%b req=%b stall=%b exp 1/0/0", bus.valid, bus.mem_req, bus.stall); end
    tick();
    gpio_in = 64'h9999AAAA_12345678;
    issue(32'h0, 1'b0, 32'h0, 4'hF);
    n_tests++; if (bus.valid !== 1'b1 || bus.rdata !== 32'h12345678 || bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL gpio_load got valid=%b data=%h req=%b exp 1/12345678/0", bus.valid, bus.rdata, bus.mem_req); end
    tick();
    issue(32'h200, 1'b1, 32'hFFFFFFFF, 4'h0);
    n_tests++; if (bus.valid !== 1'b1 || bus.mem_req !== 1'b0 || bus.stall !== 1'b0) begin n_fail++; $display("FAIL nomask_store got valid=%b req=%b stall=%b exp 1/0/0", bus.valid, bus.mem_req, bus.stall); end
    tick();
  endtask

  task automatic test_reset_mid_fill();
    int n;
    issue(32'h300, 1'b0, 32'h0, 4'hF);
    n_tests++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL rf_req got=%b exp=1", bus.mem_req); end
    tick();
    rst = 1'b1;
    #1;
    n_tests++; if (bus.mem_req !== 1'b0 || bus.stall !== 1'b1) begin n_fail++; $display("FAIL rf_abort got req=%b stall=%b exp 0/1", bus.mem_req, bus.stall); end
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h77777777;
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    bus.mem_ack = 1'b0;
    n_tests++; if (bus.valid !== 1'b0 || bus.rdata !== 32'h0 || bus.stall !== 1'b0) begin n_fail++; $display("FAIL rf_late_ack got valid=%b data=%h stall=%b exp 0/0/0", bus.valid, bus.rdata, bus.stall); end
    n_tests++; if (gpio_out !== 64'h0) begin n_fail++; $display("FAIL rf_gpio got=%h exp=0", gpio_out); end
    issue(32'h300, 1'b0, 32'h0, 4'hF);
    n_tests++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL rf_miss300 got req=%b exp 1", bus.mem_req); end
    serve(2, 32'h33333333, n);
    n_tests++; if (n !== 2 || bus.valid !== 1'b1 || bus.rdata !== 32'h33333333) begin n_fail++; $display("FAIL rf_fill got n=%0d valid=%b data=%h exp 2/1/33333333", n, bus.valid, bus.rdata); end
    tick();
    issue(32'h100, 1'b0, 32'h0, 4'hF);
    n_tests++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL rf_miss100 got req=%b exp 1", bus.mem_req); end
    serve(1, 32'hDE22BE44, n);
    n_tests++; if (n !== 1 || bus.rdata !== 32'hDE22BE44) begin n_fail++; $display("FAIL rf_fill100 got n=%0d data=%h exp 1/de22be44", n, bus.rdata); end
    tick();
  endtask

  initial begin
    bus.req = 1'b0; bus.addr = '0; bus.wdata = '0; bus.mask = '0; bus.we = 1'b0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    gpio_in = '0;
    test_reset();
    test_miss_hit();
    test_store();
    test_alias();
    test_mmio();
    test_reset_mid_fill();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
